// File: rtl/register_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register between
// issue and writeback retire, and stalls issue on RAW hazards or exhausted capacity.
module register_scoreboard #(
   parameter  int NUM_REGISTERS           = 32,
   parameter  int MAX_IN_FLIGHT           = 4,
   localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS),
   localparam int COUNT_WIDTH             = $clog2(MAX_IN_FLIGHT + 1)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               issue_valid,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_read_1,
   input  logic                               issue_read_1_valid,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_read_2,
   input  logic                               issue_read_2_valid,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_write,
   input  logic                               issue_write_valid,
   output logic                               issue_stall,
   output logic                               issue_accept,
   input  logic                               retire_valid,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] retire_register,
   input  logic                               flush,
   output logic [NUM_REGISTERS-1:0]           busy_mask,
   output logic [COUNT_WIDTH-1:0]             in_flight_count,
   output logic                               retire_error
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(MAX_IN_FLIGHT);

   logic [COUNT_WIDTH-1:0] pending      [NUM_REGISTERS];
   logic [COUNT_WIDTH-1:0] pending_next [NUM_REGISTERS];
   logic [COUNT_WIDTH-1:0] count_next;

   logic write_tracked_reg;
   logic read_1_hazard;
   logic read_2_hazard;
   logic write_full;
   logic tracked_issue;
   logic tracked_retire;
   logic retire_bad;

   // Stall looks only at registered state; a same-cycle retire does not unblock a reader.
   assign write_tracked_reg = issue_write_valid && (issue_write != '0);
   assign read_1_hazard     = issue_read_1_valid && busy_mask[issue_read_1];
   assign read_2_hazard     = issue_read_2_valid && busy_mask[issue_read_2];
   assign write_full        = write_tracked_reg &&
                              ((pending[issue_write] == COUNT_MAX) || (in_flight_count == COUNT_MAX));
   assign issue_stall       = rst || flush || read_1_hazard || read_2_hazard || write_full;
   assign issue_accept      = issue_valid && !issue_stall;

   assign tracked_issue  = issue_accept && write_tracked_reg;
   assign tracked_retire = retire_valid && (retire_register != '0) && (pending[retire_register] != '0);
   assign retire_bad     = retire_valid && (retire_register != '0) && (pending[retire_register] == '0);

   always_comb begin
      // NOTE: every comb output gets a default before any branch, so no latch is inferred.
      count_next = in_flight_count;
      for (int r = 0; r < NUM_REGISTERS; r++) begin
         pending_next[r] = pending[r];
         if (flush || r == 0) begin
            pending_next[r] = '0;
         end else begin
            unique case ({tracked_issue  && (issue_write     == REGISTER_INDEXING_WIDTH'(r)),
                          tracked_retire && (retire_register == REGISTER_INDEXING_WIDTH'(r))})
               2'b10:   pending_next[r] = pending[r] + 1'b1;
               2'b01:   pending_next[r] = pending[r] - 1'b1;
               default: pending_next[r] = pending[r];
            endcase
         end
      end
      if (flush) begin
         count_next = '0;
      end else begin
         unique case ({tracked_issue, tracked_retire})
            2'b10:   count_next = in_flight_count + 1'b1;
            2'b01:   count_next = in_flight_count - 1'b1;
            default: count_next = in_flight_count;
         endcase
      end
   end

   // NOTE: the counter array is control state, so every entry is reset, not left as RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            pending[r] <= '0;
         end
         busy_mask       <= '0;
         in_flight_count <= '0;
         retire_error    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all state updates see the same pre-edge values.
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            pending[r]   <= pending_next[r];
            busy_mask[r] <= (pending_next[r] != '0);
         end
         in_flight_count <= count_next;
         if (retire_bad && !flush) begin
            retire_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: directed scenarios followed by random
// traffic, compared against an array-of-counts reference model.
module tb_register_scoreboard;

   localparam int NR  = 32;
   localparam int MAX = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid;
   logic [4:0] issue_read_1;
   logic       issue_read_1_valid;
   logic [4:0] issue_read_2;
   logic       issue_read_2_valid;
   logic [4:0] issue_write;
   logic       issue_write_valid;
   logic       issue_stall;
   logic       issue_accept;
   logic       retire_valid;
   logic [4:0] retire_register;
   logic       flush;
   logic [31:0] busy_mask;
   logic [2:0] in_flight_count;
   logic       retire_error;

   int errors = 0;
   int checks = 0;

   int model_pend [NR];
   bit model_err;

   register_scoreboard dut (
      .clk                (clk),
      .rst                (rst),
      .issue_valid        (issue_valid),
      .issue_read_1       (issue_read_1),
      .issue_read_1_valid (issue_read_1_valid),
      .issue_read_2       (issue_read_2),
      .issue_read_2_valid (issue_read_2_valid),
      .issue_write        (issue_write),
      .issue_write_valid  (issue_write_valid),
      .issue_stall        (issue_stall),
      .issue_accept       (issue_accept),
      .retire_valid       (retire_valid),
      .retire_register    (retire_register),
      .flush              (flush),
      .busy_mask          (busy_mask),
      .in_flight_count    (in_flight_count),
      .retire_error       (retire_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int model_total();
      int s = 0;
      for (int r = 0; r < NR; r++) s += model_pend[r];
      return s;
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] m = '0;
      for (int r = 1; r < NR; r++) m[r] = (model_pend[r] > 0);
      return m;
   endfunction

   task automatic model_clear(input bit clear_err);
      for (int r = 0; r < NR; r++) model_pend[r] = 0;
      if (clear_err) model_err = 1'b0;
   endtask

   task automatic idle_inputs();
      issue_valid = 0; issue_read_1 = 0; issue_read_1_valid = 0;
      issue_read_2 = 0; issue_read_2_valid = 0; issue_write = 0;
      issue_write_valid = 0; retire_valid = 0; retire_register = 0; flush = 0;
   endtask

   // One clock cycle: drive after negedge, check comb outputs, then state after posedge.
   task automatic step(input bit iv, input int r1, input bit r1v, input int r2, input bit r2v,
                       input int w, input bit wv, input bit rv, input int rr, input bit fl);
      bit exp_stall, exp_accept, retire_ok;
      issue_valid = iv;
      issue_read_1 = 5'(r1); issue_read_1_valid = r1v;
      issue_read_2 = 5'(r2); issue_read_2_valid = r2v;
      issue_write = 5'(w);   issue_write_valid = wv;
      retire_valid = rv;     retire_register = 5'(rr);
      flush = fl;
      #1;
      exp_stall = fl || (r1v && model_pend[r1] > 0) || (r2v && model_pend[r2] > 0) ||
                  (wv && w != 0 && (model_pend[w] == MAX || model_total() == MAX));
      exp_accept = iv && !exp_stall;
      check("issue_stall", issue_stall, exp_stall);
      check("issue_accept", issue_accept, exp_accept);
      @(posedge clk);
      if (fl) begin
         model_clear(1'b0);
      end else begin
         retire_ok = rv && rr != 0 && model_pend[rr] > 0;
         if (rv && rr != 0 && !retire_ok) model_err = 1'b1;
         if (exp_accept && wv && w != 0) model_pend[w]++;
         if (retire_ok) model_pend[rr]--;
      end
      #1;
      check("busy_mask", busy_mask, model_busy());
      check("in_flight_count", 32'(in_flight_count), 32'(model_total()));
      check("retire_error", retire_error, model_err);
      @(negedge clk);
   endtask

   task automatic issue_w(input int w);
      step(1, 0, 0, 0, 0, w, 1, 0, 0, 0);
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      model_clear(1'b1);
      @(negedge clk);
      check("reset_stall", issue_stall, 1);
      check("reset_busy", busy_mask, 0);
      check("reset_count", 32'(in_flight_count), 0);
      check("reset_error", retire_error, 0);
      rst = 0;
      @(negedge clk);

      // Reset mid-run with pending[5] = 2
      issue_w(5);
      issue_w(5);
      check("pend5_count", 32'(in_flight_count), 2);
      issue_valid = 1; issue_write = 7; issue_write_valid = 1;
      rst = 1;
      #1;
      check("midrst_busy", busy_mask, 0);
      check("midrst_count", 32'(in_flight_count), 0);
      check("midrst_stall", issue_stall, 1);
      check("midrst_accept", issue_accept, 0);
      model_clear(1'b1);
      @(negedge clk);
      rst = 0;
      idle_inputs();
      issue_w(7);
      check("after_rst_busy7", busy_mask, 32'h80);

      // RAW on x3
      step(1, 0, 0, 0, 0, 7, 0, 1, 7, 0);
      issue_w(3);
      for (int i = 0; i < 3; i++) step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
      check("raw_busy_clear", busy_mask, 0);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);

      // x0 is never tracked
      issue_w(0);
      step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      check("x0_count", 32'(in_flight_count), 0);

      // Capacity
      issue_w(1); issue_w(2); issue_w(4); issue_w(6);
      check("cap_count", 32'(in_flight_count), 4);
      issue_w(9);
      step(1, 0, 0, 0, 0, 9, 1, 1, 1, 0);
      issue_w(9);
      check("cap_busy9", busy_mask[9], 1);

      // Simultaneous issue and retire on x8
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      issue_w(8);
      step(1, 0, 0, 0, 0, 8, 1, 1, 8, 0);
      check("simul_count", 32'(in_flight_count), 1);
      check("simul_busy8", busy_mask[8], 1);

      // Flush then retire error
      issue_w(11); issue_w(12);
      check("pre_flush_count", 32'(in_flight_count), 3);
      step(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
      check("flush_count", 32'(in_flight_count), 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 10, 0);
      check("err_set", retire_error, 1);
      check("err_count", 32'(in_flight_count), 0);

      // Random traffic on a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 1) == 1,
              $urandom_range(0, 7), $urandom_range(0, 2) == 0,
              $urandom_range(0, 7), $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 40) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
